// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle. Divide by zero
// and signed overflow finish without iterating.
// Build option: define MULDIV_FAST_MUL_EN to replace the iterative multiply
// with a single-cycle combinational 33x33 signed multiplier.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // MUL: {partial hi, multiplier lo}; DIV: {remainder, dividend/quotient}
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;        // multiplicand / divisor magnitude
  logic [1:0]          f3_q, f3_d;      // funct3[1:0]; funct3[2] is implied by state
  logic                neg_q, neg_d;    // negate final product/quotient/remainder
  logic [XLEN-1:0]     pend_q, pend_d;  // result presented during DONE
  logic [XLEN-1:0]     result_q, result_d;

  // Operand signedness and magnitudes at accept
  logic            sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_ovf;

  assign sgn_a   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sgn_b   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign neg_a   = sgn_a & op_a[XLEN-1];
  assign neg_b   = sgn_b & op_b[XLEN-1];
  assign mag_a   = neg_a ? -op_a : op_a;
  assign mag_b   = neg_b ? -op_b : op_b;
  assign div_ovf = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

`ifdef MULDIV_FAST_MUL_EN
  // 33x33 signed product (operands sign- or zero-extended per signedness),
  // evaluated modulo 2^64 since only the low 64 bits are ever selected.
  logic signed [2*XLEN-1:0] fm_a, fm_b, fm_prod;
  assign fm_a    = {{XLEN{neg_a}}, op_a};
  assign fm_b    = {{XLEN{neg_b}}, op_b};
  assign fm_prod = fm_a * fm_b;
`endif

  // One iteration step for each datapath
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] mul_step, div_step, mul_fin;
  logic [XLEN-1:0]   div_q, div_r;

  // Shift-add multiply and restoring-divide step logic
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};
    mul_fin   = neg_q ? -mul_step : mul_step;
    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, b_q};
    div_step  = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    div_q     = div_step[XLEN-1:0];
    div_r     = div_step[2*XLEN-1:XLEN];
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    pend_d   = pend_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          f3_d  = funct3[1:0];
          neg_d = (funct3[2] && funct3[1]) ? neg_a : (neg_a ^ neg_b);
          acc_d = {{XLEN{1'b0}}, mag_a};
          b_d   = mag_b;
          cnt_d = '0;
          if (funct3[2]) begin
            if (op_b == '0) begin
              pend_d  = funct3[1] ? op_a : '1;
              state_d = S_DONE;
            end else if (div_ovf) begin
              pend_d  = funct3[1] ? '0 : op_a;
              state_d = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            pend_d  = (funct3[1:0] == 2'b00) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
            state_d = S_DONE;
`else
            state_d = S_MUL;
`endif
          end
        end
      end
      S_MUL, S_DIV: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = (state_q == S_MUL) ? mul_step : div_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = S_DONE;
            if (state_q == S_MUL)
              pend_d = (f3_q == 2'b00) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];
            else if (f3_q[1])
              pend_d = neg_q ? -div_r : div_r;
            else
              pend_d = neg_q ? -div_q : div_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!kill) result_d = pend_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      pend_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      pend_q   <= pend_d;
      result_q <= result_d;
    end
  end

  // A kill in the DONE cycle suppresses the pulse and keeps the old result
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE) && !kill;
  assign result = done ? pend_q : result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics from plain integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint ua, ub, p;
    logic [63:0] pv;
    sa = a; sb = b;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = ua * ub; pv = p; return pv[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); pv = p; return pv[63:32]; end
      3'd2: begin p = longint'(sa) * ub; pv = p; return pv[63:32]; end
      3'd3: begin p = ua * ub; pv = p; return pv[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // Issue one op, optionally poke start while busy (poke = cycle number, 0 = none)
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int poke);
    logic [31:0] exp;
    logic [31:0] got;
    int lat;
    exp = ref_model(f, a, b);
    lat = 0;
    got = 32'h0;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      if (done) begin
        lat = i;
        got = result;
        chk("busy_at_done", {31'b0, busy}, 32'd1);
      end else begin
        chk("busy_run", {31'b0, busy}, 32'd1);
        start = (i == poke);
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat(f, a, b)));
    chk("result", got, exp);
    @(posedge clk); #1;
    chk("done_once", {31'b0, done}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("result_hold", result, exp);
    last_res = exp;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ndone;
    rst = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'd0; op_a = 0; op_b = 0;
    last_res = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases; first one also pokes start mid-multiply
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 5);
    do_op(3'd1, 32'h80000000, 32'h80000000, 0);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, 0);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 0);
    do_op(3'd5, 32'd100, 32'd7, 0);
    do_op(3'd7, 32'd100, 32'd7, 0);
    do_op(3'd4, 32'd5, 32'd0, 0);
    do_op(3'd7, 32'd5, 32'd0, 0);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0);

    // kill at T+10 of a divide
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_done", {31'b0, done}, 32'd0);
    chk("kill_result", result, last_res);
    ndone = 0;
    repeat (30) begin @(posedge clk); #1; if (done) ndone++; end
    chk("kill_no_done", 32'(ndone), 32'd0);

    // kill and start together in IDLE: nothing accepted
    @(negedge clk);
    start = 1'b1; kill = 1'b1; funct3 = 3'd4; op_a = 32'd9; op_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    chk("killstart_busy", {31'b0, busy}, 32'd0);

    // kill during DONE of a special case: pulse suppressed, result kept
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("kdone_busy", {31'b0, busy}, 32'd1);
    kill = 1'b1;
    #1;
    chk("kdone_done", {31'b0, done}, 32'd0);
    chk("kdone_result", result, last_res);
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kdone_idle", {31'b0, busy}, 32'd0);
    chk("kdone_hold", result, last_res);

    // random ops, issued back-to-back
    for (int n = 0; n < 40; n++) do_op(3'($urandom_range(0, 7)), pick(), pick(), 0);

    // async reset mid-divide, between edges
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; op_a = 32'd12345; op_b = 32'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(3'd3, 32'd2, 32'd3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
